hc_sr04_ctrl: RTL and testbench
===============================

// Module: hc_sr04_ctrl
// PURPOSE
//  Ultrasonic ranging controller for the HC-SR04 module. Downstream of the 1 us
//  tick generator: consumes its one-cycle clk_us tick to time the trigger pulse,
//  measure echo width in microseconds, convert it to centimetres and repeat
//  periodically. Results feed the UART reporting stage.
// PARAMETERS
//  TRIG_US     12     trigger high time, in clk_us ticks (>=10 per sensor spec)
//  PERIOD_US   60000  trigger-to-trigger period, in clk_us ticks
//  TIMEOUT_US  38000  max wait for echo rise plus echo high time, in ticks
//  Constraint: TRIG_US + TIMEOUT_US + 2 < PERIOD_US <= 65535
// PORTS
//  sys_clk     in   1   system clock, 50 MHz
//  sys_rst_n   in   1   asynchronous active-low reset
//  clk_us      in   1   1 us tick, high for one sys_clk cycle every 50 cycles
//  echo        in   1   sensor echo, asynchronous to sys_clk
//  trig        out  1   sensor trigger, registered
//  echo_us     out  16  last echo width in us (0 on timeout)
//  dist_cm     out  10  last distance in cm (0 on timeout)
//  data_valid  out  1   one-cycle pulse when echo_us/dist_cm/timeout update
//  timeout     out  1   level; 1 when last measurement timed out
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM=IDLE, all counters 0, sync flops 0.
//  - echo passes a 2-flop synchronizer (echo_s); rise/fall detected on echo_s
//    vs its registered copy. Edge timing is 3 sys_clk cycles late; accepted.
//  - FSM advances on sys_clk; counters advance only in cycles with clk_us=1.
//    Period counter p_cnt: cleared on TRIG entry, +1 per tick, saturates.
//  - IDLE: on first clk_us tick -> TRIG.
//  - TRIG: trig=1; t_cnt counts ticks; on tick where t_cnt==TRIG_US-1 -> WAIT_RISE,
//    trig=0. Trig high width = TRIG_US ticks (600 sys_clk at defaults).
//  - WAIT_RISE: to_cnt counts ticks from entry; echo_s rise -> MEASURE with
//    w_cnt=0; to_cnt reaching TIMEOUT_US -> DONE with timeout. An echo already
//    high on entry is not a rise; waits for a fresh rising edge.
//  - MEASURE: w_cnt +1 per tick while echo_s=1; to_cnt keeps counting.
//    echo_s fall -> DONE ok; to_cnt reaching TIMEOUT_US -> DONE timeout.
//    Fall and tick in same cycle: tick counted, then DONE.
//    Fall and timeout in same cycle: fall wins (ok result).
//  - DONE (1 cycle): ok: echo_us<=w_cnt, dist_cm<=(w_cnt*1130)>>16 (17x16 bit
//    product, truncated to 10 bits), timeout<=0. timeout: echo_us<=0,
//    dist_cm<=0, timeout<=1. data_valid=1 this cycle only. -> HOLD.
//  - HOLD: on tick with p_cnt>=PERIOD_US-1 -> TRIG. Trigger rising edges are
//    exactly PERIOD_US ticks apart.
//  - Outputs echo_us/dist_cm/timeout hold value between data_valid pulses.
//  - Reset mid-operation: trig drops immediately; restart from IDLE after release.
// TESTING
//  1 Reset held, then released with ticks every 50 cycles -> outputs 0 during
//    reset; trig rises after first tick, stays high exactly 600 sys_clk cycles.
//  2 echo high 1160 us starting 200 us after trig fall -> one data_valid,
//    echo_us=1160 (+/-1), dist_cm=20, timeout=0.
//  3 echo never rises -> data_valid 38000 ticks after WAIT_RISE entry,
//    timeout=1, echo_us=0, dist_cm=0.
//  4 echo rises, stays high 40000 us -> timeout=1 at to_cnt==38000; next
//    cycle's fresh echo of 580 us -> echo_us=580, dist_cm=10, timeout=0.
//  5 Free run, echo 300 us each cycle -> successive trig rises 60000 ticks
//    apart, exactly one data_valid per period, dist_cm=5.
//  6 sys_rst_n pulsed low mid-MEASURE -> trig, data_valid, echo_us, dist_cm,
//    timeout all 0 in the same cycle; normal trigger sequence after release.

Source files
------------

// File: rtl/hc_sr04_ctrl.sv
// rtl/hc_sr04_ctrl.sv - HC-SR04 ultrasonic ranging controller
module hc_sr04_ctrl #(
    parameter int unsigned TRIG_US    = 12,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned TIMEOUT_US = 38000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clk_us,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] echo_us,
    output logic [9:0]  dist_cm,
    output logic        data_valid,
    output logic        timeout
);

    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
    localparam logic [31:0] CM_PER_US_Q16 = 32'd1130;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        echo_meta;
    logic        echo_s;
    logic        echo_d;
    logic        echo_rise;
    logic        echo_fall;

    logic [15:0] t_cnt;
    logic [15:0] p_cnt;
    logic [15:0] to_cnt;
    logic [15:0] w_cnt;
    logic        meas_timeout;
    logic        window_expired;

    logic        trig_next;
    logic        dv_next;
    logic [9:0]  dist_calc;

    // Two-flop synchronizer plus one more stage for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_rise      = echo_s & ~echo_d;
    assign echo_fall      = ~echo_s & echo_d;
    assign window_expired = clk_us && (to_cnt >= TIMEOUT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clk_us) begin
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (clk_us && (t_cnt == TRIG_LAST)) begin
                    state_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (window_expired) begin
                    state_next = ST_DONE;
                end else if (echo_rise) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (echo_fall || window_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (clk_us && (p_cnt >= PERIOD_LAST)) begin
                    state_next = ST_TRIG;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        trig_next = (state_next == ST_TRIG);
        dv_next   = (state == ST_DONE);
    end

    // Counters only move on microsecond ticks; entry into a state clears them
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t_cnt  <= '0;
            p_cnt  <= '0;
            to_cnt <= '0;
            w_cnt  <= '0;
        end else begin
            if (state != ST_TRIG) begin
                t_cnt <= '0;
            end else if (clk_us) begin
                t_cnt <= t_cnt + 16'd1;
            end

            if ((state_next == ST_TRIG) && (state != ST_TRIG)) begin
                p_cnt <= '0;
            end else if (clk_us && (p_cnt != 16'hffff)) begin
                p_cnt <= p_cnt + 16'd1;
            end

            if (state == ST_TRIG) begin
                to_cnt <= '0;
            end else if (clk_us && ((state == ST_WAIT_RISE) || (state == ST_MEASURE))) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (state == ST_WAIT_RISE) begin
                w_cnt <= '0;
            end else if (clk_us && (state == ST_MEASURE)) begin
                w_cnt <= w_cnt + 16'd1;
            end
        end
    end

    // A fall wins over an expiring window in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meas_timeout <= 1'b0;
        end else if ((state_next == ST_DONE) && (state != ST_DONE)) begin
            meas_timeout <= !((state == ST_MEASURE) && echo_fall);
        end
    end

    // 1130/65536 cm per us approximates the 343 m/s round trip
    assign dist_calc = 10'((32'(w_cnt) * CM_PER_US_Q16) >> 16);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            trig       <= 1'b0;
            data_valid <= 1'b0;
            echo_us    <= '0;
            dist_cm    <= '0;
            timeout    <= 1'b0;
        end else begin
            trig       <= trig_next;
            data_valid <= dv_next;
            if (state == ST_DONE) begin
                if (meas_timeout) begin
                    echo_us <= '0;
                    dist_cm <= '0;
                    timeout <= 1'b1;
                end else begin
                    echo_us <= w_cnt;
                    dist_cm <= dist_calc;
                    timeout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hc_sr04_ctrl.sv
// tb/tb_hc_sr04_ctrl.sv - self-checking bench for hc_sr04_ctrl
module tb_hc_sr04_ctrl;

    localparam int D          = 2;
    localparam int TRIG_US    = 12;
    localparam int PERIOD_US  = 1600;
    localparam int TIMEOUT_US = 1500;
    localparam int WAIT_LIMIT = 2 * PERIOD_US * D;
    localparam int NVEC       = 7;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        clk_us;
    logic        echo;
    logic        trig;
    logic [15:0] echo_us;
    logic [9:0]  dist_cm;
    logic        data_valid;
    logic        timeout;

    hc_sr04_ctrl #(
        .TRIG_US   (TRIG_US),
        .PERIOD_US (PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_us    (clk_us),
        .echo      (echo),
        .trig      (trig),
        .echo_us   (echo_us),
        .dist_cm   (dist_cm),
        .data_valid(data_valid),
        .timeout   (timeout)
    );

    typedef struct {
        int w;
        bit to;
        int dist_lit;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // delay after trig fall, echo width (0 = no echo), hand-computed distance
    int vec_delay [NVEC] = '{200,  0,   10, 50,  30,  30,  30};
    int vec_width [NVEC] = '{1160, 0, 1540, 580, 300, 300, 300};
    int vec_dist  [NVEC] = '{20,   0,    0, 10,  5,   5,   5};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        int ph;
        ph = 0;
        clk_us = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            clk_us = (ph == 0);
            ph = (ph + 1) % D;
        end
    end

    initial begin
        repeat (60000) @(posedge sys_clk);
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference behaviour: trigger width/period, one result per period, held outputs
    initial begin
        int   cyc;
        int   last_rise;
        int   trig_run;
        int   dv_since_rise;
        int   ticks_since_rst;
        int   fall_ticks;
        bit   first_pending;
        bit   counting;
        bit   prev_trig;
        int   held_echo;
        int   held_dist;
        int   held_to;
        exp_t e;
        cyc = 0; last_rise = 0; trig_run = 0; dv_since_rise = 0;
        ticks_since_rst = 0; fall_ticks = 0; first_pending = 1; counting = 0;
        prev_trig = 0; held_echo = 0; held_dist = 0; held_to = 0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!sys_rst_n) begin
                check("reset_outputs", longint'({trig, data_valid, echo_us, dist_cm, timeout}), 0);
                held_echo = 0; held_dist = 0; held_to = 0;
                trig_run = 0; ticks_since_rst = 0; first_pending = 1;
                counting = 0; prev_trig = 0; dv_since_rise = 0;
            end else begin
                if (trig && !prev_trig) begin
                    if (first_pending) begin
                        check("first_rise_ticks", ticks_since_rst, 1);
                        first_pending = 0;
                    end else begin
                        check("period_cycles", cyc - last_rise, PERIOD_US * D);
                        check("dv_per_period", dv_since_rise, 1);
                    end
                    last_rise = cyc;
                    dv_since_rise = 0;
                end
                if (trig) trig_run++;
                if (!trig && prev_trig) begin
                    check("trig_width", trig_run, TRIG_US * D);
                    trig_run = 0;
                    counting = 1;
                    fall_ticks = 0;
                end
                if (data_valid) begin
                    dv_since_rise++;
                    if (exp_q.size() == 0) begin
                        check("dv_unexpected", int'(data_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        held_echo = e.to ? 0 : e.w;
                        held_dist = e.to ? 0 : ((e.w * 1130) >> 16);
                        held_to   = e.to ? 1 : 0;
                        check("echo_us", echo_us, held_echo);
                        check("dist_cm_model", dist_cm, held_dist);
                        check("dist_cm_literal", dist_cm, e.dist_lit);
                        check("timeout", timeout, held_to);
                        if (e.to) check("timeout_ticks", fall_ticks, TIMEOUT_US);
                    end
                    counting = 0;
                end else begin
                    check("hold_outputs", longint'({echo_us, dist_cm, timeout}),
                          longint'({16'(held_echo), 10'(held_dist), 1'(held_to)}));
                end
                if (counting && clk_us) fall_ticks++;
                if (clk_us) ticks_since_rst++;
                prev_trig = trig;
            end
        end
    end

    task automatic wait_trig(input logic val, input string name);
        int n;
        n = 0;
        while (trig !== val && n < WAIT_LIMIT) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (trig !== val) check(name, int'(trig), int'(val));
    endtask

    task automatic run_period(input int delay, input int width, input int lit);
        exp_t e;
        wait_trig(1'b1, "wait_trig_rise");
        wait_trig(1'b0, "wait_trig_fall");
        e.w        = width;
        e.to       = (width == 0) || (delay + width >= TIMEOUT_US);
        e.dist_lit = lit;
        exp_q.push_back(e);
        if (width > 0) begin
            repeat (delay * D) @(posedge sys_clk);
            #1;
            echo = 1'b1;
            repeat (width * D) @(posedge sys_clk);
            #1;
            echo = 1'b0;
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        echo      = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_period(vec_delay[i], vec_width[i], vec_dist[i]);
        end

        // Reset in the middle of a measurement
        wait_trig(1'b1, "wait_trig_rise");
        wait_trig(1'b0, "wait_trig_fall");
        repeat (30 * D) @(posedge sys_clk);
        #1;
        echo = 1'b1;
        repeat (100 * D) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_trig", trig, 0);
        check("midrst_data_valid", data_valid, 0);
        check("midrst_echo_us", echo_us, 0);
        check("midrst_dist_cm", dist_cm, 0);
        check("midrst_timeout", timeout, 0);
        echo = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        run_period(40, 580, 10);
        wait_trig(1'b1, "wait_trig_rise");
        repeat (4) @(posedge sys_clk);
        check("pending_results", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
